// File: rtl/larpix_channel_pkg.sv
// Shared types for the LArPix channel sequencer.
//   chan_state_t : sequencer FSM states
//   chan_event_t : {timeout, timestamp, adc} event word at the default widths
//   eff_width    : pulse width with 0 promoted to 1
package larpix_channel_pkg;

   localparam int ADCBITS_DEF = 10;
   localparam int TS_BITS_DEF = 24;

   typedef enum logic [2:0] {IDLE, SAMPLE, CONVERT, STORE, RESET} chan_state_t;

   typedef struct packed {
      logic                   timeout;
      logic [TS_BITS_DEF-1:0] ts;
      logic [ADCBITS_DEF-1:0] adc;
   } chan_event_t;

   function automatic logic [7:0] eff_width(input logic [7:0] w);
      return (w == 8'd0) ? 8'd1 : w;
   endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous event FIFO with extra-bit pointers for full/empty.
//   push/wdata : write request; ignored when full (even if popping the same cycle)
//   pop        : read request; ignored when empty
//   rdata      : head entry, read straight out of the storage flops
//   full/empty : occupancy flags
module event_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/channel_sequencer.sv
// Per-channel digital sequencer: hit -> sample -> convert -> store -> CSA reset.
//   clk, reset_n          : clock, async active-low reset
//   enable                : gates discriminator hits (external_trigger bypasses it)
//   external_trigger      : one-cycle forced event, synchronous to clk
//   sample_cycles/reset_cycles : pulse widths, 0 treated as 1
//   hit, done             : async inputs, 2-flop synchronized
//   dout                  : ADC result, stable while done is high
//   sample, csa_reset     : analog front-end controls
//   event_data/valid/ready: event FIFO head, valid/ready drain
//   overflow              : sticky, an event was dropped on a full FIFO
//   busy                  : FSM not in IDLE
module channel_sequencer
   import larpix_channel_pkg::*;
#(
   parameter int ADCBITS        = 10,
   parameter int TS_BITS        = 24,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic                       external_trigger,
   input  logic [7:0]                 sample_cycles,
   input  logic [7:0]                 reset_cycles,
   input  logic                       hit,
   input  logic                       done,
   input  logic [ADCBITS-1:0]         dout,
   output logic                       sample,
   output logic                       csa_reset,
   output logic [TS_BITS+ADCBITS:0]   event_data,
   output logic                       event_valid,
   input  logic                       event_ready,
   output logic                       overflow,
   output logic                       busy
);

   localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   chan_state_t         state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [TS_BITS-1:0]  ts_q, ts_d, ts_lat_q, ts_lat_d;
   logic [ADCBITS-1:0]  adc_q, adc_d;
   logic                tflag_q, tflag_d;
   logic                overflow_q, overflow_d;
   logic                hit_m_q, hit_s_q, done_m_q, done_s_q;
   logic                fifo_push, fifo_pop, fifo_full, fifo_empty;

   // State register (plus synchronizers and datapath flops)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= RESET;
         cnt_q      <= 8'd1;    // one csa_reset cycle after release
         tmo_q      <= '0;
         ts_q       <= '0;
         ts_lat_q   <= '0;
         adc_q      <= '0;
         tflag_q    <= 1'b0;
         overflow_q <= 1'b0;
         hit_m_q    <= 1'b0;
         hit_s_q    <= 1'b0;
         done_m_q   <= 1'b0;
         done_s_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         ts_q       <= ts_d;
         ts_lat_q   <= ts_lat_d;
         adc_q      <= adc_d;
         tflag_q    <= tflag_d;
         overflow_q <= overflow_d;
         hit_m_q    <= hit;
         hit_s_q    <= hit_m_q;
         done_m_q   <= done;
         done_s_q   <= done_m_q;
      end
   end

   // Next-state
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      ts_d       = ts_q + TS_BITS'(1);
      ts_lat_d   = ts_lat_q;
      adc_d      = adc_q;
      tflag_d    = tflag_q;
      overflow_d = overflow_q | ((state_q == STORE) & fifo_full);
      case (state_q)
         IDLE: begin
            if ((enable & hit_s_q) | external_trigger) begin
               state_d  = SAMPLE;
               ts_lat_d = ts_q;
               cnt_d    = eff_width(sample_cycles);
            end
         end
         SAMPLE: begin
            if (cnt_q == 8'd1) begin
               state_d = CONVERT;
               tmo_d   = '0;
               tflag_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         CONVERT: begin
            // done wins over a timeout landing in the same cycle
            if (done_s_q) begin
               adc_d   = dout;
               state_d = STORE;
            end else if (tmo_q == TMO_LAST) begin
               adc_d   = '0;
               tflag_d = 1'b1;
               state_d = STORE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         STORE: begin
            state_d = RESET;
            cnt_d   = eff_width(reset_cycles);
         end
         RESET: begin
            if (cnt_q == 8'd1) state_d = IDLE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         default: state_d = RESET;
      endcase
   end

   // Outputs
   always_comb begin
      sample    = (state_q == SAMPLE);
      csa_reset = (state_q == RESET);
      busy      = (state_q != IDLE);
      fifo_push = (state_q == STORE);
      fifo_pop  = ~fifo_empty & event_ready;
   end

   assign event_valid = ~fifo_empty;
   assign overflow    = overflow_q;

   event_fifo #(
      .WIDTH (TS_BITS + ADCBITS + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .wdata   ({tflag_q, ts_lat_q, adc_q}),
      .pop     (fifo_pop),
      .rdata   (event_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_channel_sequencer.sv
module tb_channel_sequencer;
   import larpix_channel_pkg::*;

   logic        clk = 1'b0, reset_n = 1'b1, enable = 1'b0, external_trigger = 1'b0;
   logic        hit = 1'b0, done = 1'b0, event_ready = 1'b0;
   logic [7:0]  sample_cycles = 8'd1, reset_cycles = 8'd1;
   logic [9:0]  dout = '0;
   logic        sample, csa_reset, event_valid, overflow, busy;
   logic [34:0] event_data;
   chan_event_t ev;
   int          total = 0, bad = 0;
   logic [23:0] ts_m;

   // ADC model: done rises adc_delay cycles after sample falls, clears on sample
   logic        adc_en = 1'b0, adc_arm = 1'b0;
   int          adc_delay = 2, adc_cnt = 0;
   logic [9:0]  adc_val = '0;

   assign ev = event_data;
   always #5 clk = ~clk;

   always @(posedge clk or negedge reset_n)
      if (!reset_n) ts_m <= '0; else ts_m <= ts_m + 24'd1;

   always @(posedge clk) begin
      if (!adc_en) begin
         done <= 1'b0; adc_arm <= 1'b0;
      end else if (sample) begin
         done <= 1'b0; adc_arm <= 1'b1; adc_cnt <= 0;
      end else if (adc_arm) begin
         if (adc_cnt == adc_delay - 1) begin
            done <= 1'b1; dout <= adc_val; adc_arm <= 1'b0;
         end else adc_cnt <= adc_cnt + 1;
      end
   end

   channel_sequencer dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .external_trigger(external_trigger),
      .sample_cycles(sample_cycles), .reset_cycles(reset_cycles), .hit(hit), .done(done),
      .dout(dout), .sample(sample), .csa_reset(csa_reset), .event_data(event_data),
      .event_valid(event_valid), .event_ready(event_ready), .overflow(overflow), .busy(busy)
   );

   task automatic test_reset();
      #1 reset_n = 1'b0;
      #3;
      total++; if (csa_reset !== 1'b1) begin bad++; $display("FAIL rst_csa: got %b want 1", csa_reset); end
      total++; if (sample !== 1'b0) begin bad++; $display("FAIL rst_sample: got %b want 0", sample); end
      total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", event_valid); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b want 1", busy); end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      total++; if (csa_reset !== 1'b1) begin bad++; $display("FAIL rel_csa1: got %b want 1", csa_reset); end
      @(negedge clk);
      total++; if (csa_reset !== 1'b0) begin bad++; $display("FAIL rel_csa0: got %b want 0", csa_reset); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rel_busy: got %b want 0", busy); end
      total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL rel_valid: got %b want 0", event_valid); end
   endtask

   task automatic test_hit_event();
      int first = -1, scnt = 0, rcnt = 0, nev = 0, g = 0;
      logic [34:0] got = '0;
      enable = 1'b1; sample_cycles = 8'd4; reset_cycles = 8'd8; event_ready = 1'b1;
      adc_en = 1'b1; adc_delay = 20; adc_val = 10'h2A5;
      while (ts_m != 24'd100 && g < 300) begin @(posedge clk); #1; g++; end
      hit = 1'b1;
      @(posedge clk); #1 hit = 1'b0;
      for (int c = 1; c <= 90; c++) begin
         @(negedge clk);
         if (sample) begin if (first < 0) first = c; scnt++; end
         if (csa_reset) rcnt++;
         if (event_valid) begin nev++; got = event_data; end
      end
      total++; if (first != 3) begin bad++; $display("FAIL hit_latency: got %0d want 3", first); end
      total++; if (scnt != 4) begin bad++; $display("FAIL hit_sample_w: got %0d want 4", scnt); end
      total++; if (rcnt != 8) begin bad++; $display("FAIL hit_reset_w: got %0d want 8", rcnt); end
      total++; if (nev != 1) begin bad++; $display("FAIL hit_nev: got %0d want 1", nev); end
      total++; if (got !== {1'b0, 24'd102, 10'h2A5}) begin bad++; $display("FAIL hit_data: got %h want %h", got, {1'b0, 24'd102, 10'h2A5}); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL hit_idle: got %b want 0", busy); end
   endtask

   task automatic test_timeout();
      int scnt = 0, rcnt = 0, conv = 0, nev = 0;
      logic [34:0] got = '0;
      logic [23:0] tv;
      enable = 1'b0; adc_en = 1'b0; sample_cycles = 8'd0; reset_cycles = 8'd0; event_ready = 1'b1;
      hit = 1'b1;
      repeat (6) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL dis_hit: got busy %b want 0", busy); end
      hit = 1'b0;
      @(posedge clk); #1 external_trigger = 1'b1; tv = ts_m;
      @(posedge clk); #1 external_trigger = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (sample) scnt++;
         if (csa_reset) rcnt++;
         if (busy && !sample && !csa_reset) conv++;
         if (event_valid) begin nev++; got = event_data; end
      end
      total++; if (scnt != 1) begin bad++; $display("FAIL to_sample_w: got %0d want 1", scnt); end
      total++; if (conv != 65) begin bad++; $display("FAIL to_conv_cycles: got %0d want 65", conv); end
      total++; if (rcnt != 1) begin bad++; $display("FAIL to_reset_w: got %0d want 1", rcnt); end
      total++; if (nev != 1) begin bad++; $display("FAIL to_nev: got %0d want 1", nev); end
      total++; if (got !== {1'b1, tv, 10'd0}) begin bad++; $display("FAIL to_data: got %h want %h", got, {1'b1, tv, 10'd0}); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle: got %b want 0", busy); end
   endtask

   task automatic test_overflow();
      logic [34:0] exp_ev [5];
      int n = 0;
      enable = 1'b1; adc_en = 1'b1; adc_delay = 2; sample_cycles = 8'd4; reset_cycles = 8'd1;
      event_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         adc_val = 10'h100 + 10'(k);
         @(posedge clk); #1 external_trigger = 1'b1; exp_ev[k] = {1'b0, ts_m, 10'h100 + 10'(k)};
         @(posedge clk); #1 external_trigger = 1'b0;
         for (int i = 0; i < 200 && busy; i++) @(negedge clk);
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovf_wait%0d: busy %b want 0", k, busy); end
         if (k == 3) begin
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
         end
      end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
      total++; if (event_data !== exp_ev[0]) begin bad++; $display("FAIL ovf_head: got %h want %h", event_data, exp_ev[0]); end
      repeat (3) @(negedge clk);
      total++; if (event_data !== exp_ev[0]) begin bad++; $display("FAIL ovf_stable: got %h want %h", event_data, exp_ev[0]); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (event_valid) begin
            total++;
            if (n > 3 || event_data !== exp_ev[n]) begin
               bad++; $display("FAIL drain%0d: got %h want %h", n, event_data, exp_ev[n > 3 ? 3 : n]);
            end
            n++;
         end
         event_ready = 1'b1;
      end
      total++; if (n != 4) begin bad++; $display("FAIL drain_cnt: got %0d want 4", n); end
      total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", event_valid); end
   endtask

   task automatic test_hit_held_once();
      int rises = 0, nev = 0;
      logic ps = 1'b0;
      enable = 1'b1; adc_en = 1'b1; adc_delay = 2; adc_val = 10'h0AA;
      sample_cycles = 8'd4; reset_cycles = 8'd4; event_ready = 1'b1;
      @(posedge clk); #1 hit = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (sample && !ps) rises++;
         if (csa_reset) hit = 1'b0;
         if (event_valid) nev++;
         ps = sample;
      end
      total++; if (rises != 1) begin bad++; $display("FAIL held_once_rises: got %0d want 1", rises); end
      total++; if (nev != 1) begin bad++; $display("FAIL held_once_nev: got %0d want 1", nev); end
   endtask

   task automatic test_hit_held_repeat();
      int rises = 0, falls = 0, r2 = -1, f1 = -1, nev = 0;
      logic ps = 1'b0, pr = 1'b0;
      enable = 1'b1; adc_en = 1'b1; adc_delay = 2; adc_val = 10'h155;
      sample_cycles = 8'd4; reset_cycles = 8'd4; event_ready = 1'b1;
      @(posedge clk); #1 hit = 1'b1;
      for (int c = 1; c <= 120; c++) begin
         @(negedge clk);
         if (sample && !ps) begin rises++; if (rises == 2) begin r2 = c; hit = 1'b0; end end
         if (!csa_reset && pr) begin falls++; if (falls == 1) f1 = c; end
         if (event_valid) nev++;
         ps = sample; pr = csa_reset;
      end
      total++; if (rises != 2) begin bad++; $display("FAIL held_rep_rises: got %0d want 2", rises); end
      total++; if (r2 != f1 + 1) begin bad++; $display("FAIL held_rep_gap: got %0d want %0d", r2, f1 + 1); end
      total++; if (nev != 2) begin bad++; $display("FAIL held_rep_nev: got %0d want 2", nev); end
   endtask

   task automatic test_ts_wrap();
      logic [34:0] got [2];
      int nev = 0, cnt = 0;
      logic [23:0] t2;
      enable = 1'b1; adc_en = 1'b1; adc_delay = 2; adc_val = 10'h3C3;
      sample_cycles = 8'd4; reset_cycles = 8'd1; event_ready = 1'b1;
      got[0] = '0; got[1] = '0;
      // Park the counter at FFFFFE, then line the forced and real values up at FFFFFF
      @(posedge clk); #1 force dut.ts_q = 24'hFFFFFE;
      @(negedge clk);
      force dut.ts_q = 24'hFFFFFF;
      release dut.ts_q;
      external_trigger = 1'b1;
      @(posedge clk); #1 external_trigger = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (event_valid && nev < 2) begin got[nev] = event_data; nev++; end
         @(posedge clk); #1 cnt++;
      end
      // cnt now equals the ts value of the current cycle (counter was 0 when cnt was 0)
      external_trigger = 1'b1; t2 = 24'(cnt);
      @(posedge clk); #1 external_trigger = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (event_valid && nev < 2) begin got[nev] = event_data; nev++; end
      end
      total++; if (nev != 2) begin bad++; $display("FAIL wrap_nev: got %0d want 2", nev); end
      total++; if (got[0] !== {1'b0, 24'hFFFFFF, 10'h3C3}) begin bad++; $display("FAIL wrap_ts_max: got %h want %h", got[0], {1'b0, 24'hFFFFFF, 10'h3C3}); end
      total++; if (got[1] !== {1'b0, t2, 10'h3C3}) begin bad++; $display("FAIL wrap_ts_after: got %h want %h", got[1], {1'b0, t2, 10'h3C3}); end
   endtask

   task automatic test_reset_abort();
      int nev = 0;
      logic [34:0] got = '0;
      enable = 1'b1; adc_en = 1'b0; sample_cycles = 8'd4; reset_cycles = 8'd1; event_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1 external_trigger = 1'b1;
      @(posedge clk); #1 external_trigger = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      total++; if (!(busy && !sample && !csa_reset)) begin bad++; $display("FAIL abort_in_conv: busy %b sample %b csa %b want 1 0 0", busy, sample, csa_reset); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL abort_ovf_sticky: got %b want 1", overflow); end
      #3 reset_n = 1'b0;
      #1;
      total++; if (csa_reset !== 1'b1) begin bad++; $display("FAIL abort_csa: got %b want 1", csa_reset); end
      total++; if (sample !== 1'b0) begin bad++; $display("FAIL abort_sample: got %b want 0", sample); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b want 1", busy); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL abort_ovf: got %b want 0", overflow); end
      total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", event_valid); end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1 external_trigger = 1'b1;
      @(posedge clk); #1 external_trigger = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (event_valid) begin nev++; got = event_data; end
      end
      total++; if (nev != 1) begin bad++; $display("FAIL abort_nev: got %0d want 1", nev); end
      total++; if (got !== {1'b1, 24'd5, 10'd0}) begin bad++; $display("FAIL abort_post_ev: got %h want %h", got, {1'b1, 24'd5, 10'd0}); end
   endtask

   initial begin
      test_reset();
      test_hit_event();
      test_timeout();
      test_overflow();
      test_hit_held_once();
      test_hit_held_repeat();
      test_ts_wrap();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
